serial_add_ctrl: RTL and testbench

- Bit-serial adder controller. One full-adder cell (A, B, Cin -> Sum, Cout) is sequenced LSB-first over WIDTH cycles.
- The carry is held in a flip-flop between cycles; operands and the partial sum are held in shift registers.
- Sits between a requesting datapath and the single shared adder cell, trading latency for area.
- Simple start/busy/done handshake; the result stays stable until the next accepted request.

---
 rtl/serial_add_ctrl.sv | 148 ++++++++++++++
 tb/tb_serial_add_ctrl.sv | 194 +++++++++++++++++++
 2 files changed

// File: rtl/serial_add_ctrl.sv
// rtl/serial_add_ctrl.sv - bit-serial adder controller sequencing one structural full adder LSB-first

module serial_add_fa (
    input  logic a,
    input  logic b,
    input  logic ci,
    output logic s,
    output logic co
);
    logic p;

    assign p  = a ^ b;
    assign s  = p ^ ci;
    assign co = (a & b) | (ci & p);
endmodule

module serial_add_ctrl #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] sum,
    output logic             cout,
    output logic             ovf
);
    localparam int CW = $clog2(WIDTH + 1);
    localparam logic [CW-1:0] LAST_BIT = CW'(WIDTH - 1);

    typedef enum logic [1:0] {S_IDLE, S_RUN, S_DONE} state_t;

    state_t           state_q, state_d;
    logic [WIDTH-1:0] a_sh_q, a_sh_d;
    logic [WIDTH-1:0] b_sh_q, b_sh_d;
    logic [WIDTH-1:0] ps_q, ps_d;
    logic [WIDTH-1:0] sum_q, sum_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic             carry_q, carry_d;
    logic             busy_q, busy_d;
    logic             done_q, done_d;
    logic             cout_q, cout_d;
    logic             ovf_q, ovf_d;

    logic             fa_s, fa_co;
    logic [WIDTH-1:0] ps_shift;

    serial_add_fa u_fa (
        .a  (a_sh_q[0]),
        .b  (b_sh_q[0]),
        .ci (carry_q),
        .s  (fa_s),
        .co (fa_co)
    );

    always_comb begin
        state_d = state_q;
        a_sh_d  = a_sh_q;
        b_sh_d  = b_sh_q;
        ps_d    = ps_q;
        sum_d   = sum_q;
        cnt_d   = cnt_q;
        carry_d = carry_q;
        busy_d  = busy_q;
        done_d  = 1'b0;
        cout_d  = cout_q;
        ovf_d   = ovf_q;

        // New sum bit enters at the MSB so that after WIDTH passes bit i sits at position i.
        ps_shift            = ps_q >> 1;
        ps_shift[WIDTH-1]   = fa_s;

        case (state_q)
            S_IDLE: begin
                if (start) begin
                    a_sh_d  = a;
                    b_sh_d  = b;
                    carry_d = cin;
                    cnt_d   = '0;
                    ps_d    = '0;
                    busy_d  = 1'b1;
                    state_d = S_RUN;
                end
            end
            S_RUN: begin
                a_sh_d  = a_sh_q >> 1;
                b_sh_d  = b_sh_q >> 1;
                ps_d    = ps_shift;
                carry_d = fa_co;
                cnt_d   = cnt_q + CW'(1);
                if (cnt_q == LAST_BIT) begin
                    // carry_q still holds the carry into the MSB on this pass.
                    sum_d   = ps_shift;
                    cout_d  = fa_co;
                    ovf_d   = carry_q ^ fa_co;
                    done_d  = 1'b1;
                    state_d = S_DONE;
                end
            end
            S_DONE: begin
                busy_d  = 1'b0;
                state_d = S_IDLE;
            end
            default: begin
                busy_d  = 1'b0;
                state_d = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= S_IDLE;
            a_sh_q  <= '0;
            b_sh_q  <= '0;
            ps_q    <= '0;
            sum_q   <= '0;
            cnt_q   <= '0;
            carry_q <= 1'b0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            cout_q  <= 1'b0;
            ovf_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            a_sh_q  <= a_sh_d;
            b_sh_q  <= b_sh_d;
            ps_q    <= ps_d;
            sum_q   <= sum_d;
            cnt_q   <= cnt_d;
            carry_q <= carry_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
            cout_q  <= cout_d;
            ovf_q   <= ovf_d;
        end
    end

    assign busy = busy_q;
    assign done = done_q;
    assign sum  = sum_q;
    assign cout = cout_q;
    assign ovf  = ovf_q;
endmodule

// File: tb/tb_serial_add_ctrl.sv
// tb/tb_serial_add_ctrl.sv - randomized self-checking bench for serial_add_ctrl

module tb_serial_add_ctrl;
    localparam int W = 8;

    logic         clk = 1'b0;
    logic         rst = 1'b1;
    logic         start = 1'b0;
    logic [W-1:0] a = '0;
    logic [W-1:0] b = '0;
    logic         cin = 1'b0;
    logic         busy, done, cout, ovf;
    logic [W-1:0] sum;

    int n_vec = 0;
    int n_err = 0;
    logic [W-1:0] held_sum;
    logic         held_cout, held_ovf;

    serial_add_ctrl #(.WIDTH(W)) dut (
        .clk   (clk),
        .rst   (rst),
        .start (start),
        .a     (a),
        .b     (b),
        .cin   (cin),
        .busy  (busy),
        .done  (done),
        .sum   (sum),
        .cout  (cout),
        .ovf   (ovf)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    // Reference: plain integer addition; overflow when like-signed operands give an unlike-signed result.
    function automatic logic [W+1:0] model(input logic [W-1:0] ma, input logic [W-1:0] mb, input logic mc);
        int unsigned tot;
        logic [W-1:0] s;
        logic co, ov;
        tot = int'(ma) + int'(mb) + int'(mc);
        s   = W'(tot % (1 << W));
        co  = (tot >= (1 << W));
        ov  = (ma[W-1] == mb[W-1]) && (s[W-1] != ma[W-1]);
        return {ov, co, s};
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_idle();
        int i;
        for (i = 0; i < 40; i++) begin
            if (!busy) break;
            tick();
        end
        if (i == 40) chk("idle_timeout", 32'(busy), 32'd0);
    endtask

    task automatic do_op(input logic [W-1:0] ta, input logic [W-1:0] tbv, input logic tc, input string tag);
        logic [W+1:0] exp;
        int  lat, bcnt;
        bit  got, held_ok;
        exp = model(ta, tbv, tc);
        wait_idle();
        a = ta; b = tbv; cin = tc; start = 1'b1;
        tick();
        start = 1'b0;
        a = W'($urandom); b = W'($urandom); cin = 1'($urandom);
        lat = 0; bcnt = 0; got = 0; held_ok = 1;
        for (int i = 0; i < W + 10; i++) begin
            if (busy) bcnt++;
            if (done) begin got = 1; break; end
            if (sum !== held_sum || cout !== held_cout || ovf !== held_ovf) held_ok = 0;
            tick();
            lat++;
        end
        chk({tag, "_done_seen"}, 32'(got), 32'd1);
        chk({tag, "_latency"}, 32'(lat), 32'(W));
        chk({tag, "_hold"}, 32'(held_ok), 32'd1);
        chk({tag, "_result"}, {22'd0, ovf, cout, sum}, {22'd0, exp});
        tick();
        chk({tag, "_post"}, {30'd0, busy, done}, 32'd0);
        chk({tag, "_busy_cycles"}, 32'(bcnt), 32'(W + 1));
        held_sum = exp[W-1:0]; held_cout = exp[W]; held_ovf = exp[W+1];
    endtask

    initial begin
        int ndone, period, t0, seen;
        logic [W+1:0] e;
        held_sum = '0; held_cout = 1'b0; held_ovf = 1'b0;

        tick();
        chk("reset_outputs", {27'd0, busy, done, cout, ovf, 1'b0}, 32'd0);
        chk("reset_sum", 32'(sum), 32'd0);
        tick();
        rst = 1'b0;
        tick();

        do_op(8'h5A, 8'h3C, 1'b0, "basic");
        chk("basic_const", {22'd0, ovf, cout, sum}, {22'd0, 1'b1, 1'b0, 8'h96});
        do_op(8'hFF, 8'h01, 1'b0, "carry_chain");
        do_op(8'hFF, 8'hFF, 1'b1, "carry_in");
        do_op(8'h80, 8'h80, 1'b0, "neg_ovf");

        // Starts during RUN and DONE must be ignored.
        wait_idle();
        a = 8'h01; b = 8'h01; cin = 1'b0; start = 1'b1;
        tick();
        start = 1'b0;
        tick(); tick();
        a = 8'h10; b = 8'h10; start = 1'b1;
        tick();
        start = 1'b0;
        ndone = 0;
        for (int i = 0; i < 20 && !done; i++) tick();
        if (done) ndone++;
        a = 8'h10; b = 8'h10; start = 1'b1;
        tick();
        start = 1'b0;
        for (int i = 0; i < 12; i++) begin
            if (done) ndone++;
            tick();
        end
        chk("ignore_single_done", 32'(ndone), 32'd1);
        chk("ignore_sum", 32'(sum), 32'h02);
        chk("ignore_idle", 32'(busy), 32'd0);
        held_sum = 8'h02; held_cout = 1'b0; held_ovf = 1'b0;
        do_op(8'h10, 8'h10, 1'b0, "after_ignore");
        chk("after_ignore_const", 32'(sum), 32'h20);

        // Reset mid-run abandons the operation and clears outputs at once.
        wait_idle();
        a = 8'h0F; b = 8'h01; start = 1'b1;
        tick();
        start = 1'b0;
        tick(); tick(); tick();
        rst = 1'b1;
        #1;
        chk("midrst_outputs", {27'd0, busy, done, cout, ovf, 1'b0}, 32'd0);
        chk("midrst_sum", 32'(sum), 32'd0);
        seen = 0;
        for (int i = 0; i < 3; i++) begin
            tick();
            if (done) seen = 1;
        end
        rst = 1'b0;
        for (int i = 0; i < 10; i++) begin
            tick();
            if (done) seen = 1;
        end
        chk("midrst_no_done", 32'(seen), 32'd0);
        held_sum = '0; held_cout = 1'b0; held_ovf = 1'b0;
        do_op(8'h03, 8'h04, 1'b0, "after_rst");

        // Continuous start: one op per W+2 cycles.
        wait_idle();
        a = 8'h33; b = 8'h44; cin = 1'b1; start = 1'b1;
        period = 0; t0 = -1; seen = 0;
        for (int i = 0; i < 60 && seen < 2; i++) begin
            tick();
            if (done) begin
                seen++;
                if (t0 >= 0) period = i - t0;
                t0 = i;
            end
        end
        start = 1'b0;
        chk("retrigger_period", 32'(period), 32'(W + 2));
        e = model(8'h33, 8'h44, 1'b1);
        chk("retrigger_result", {22'd0, ovf, cout, sum}, {22'd0, e});
        held_sum = e[W-1:0]; held_cout = e[W]; held_ovf = e[W+1];
        wait_idle();
        tick();

        for (int k = 0; k < 40; k++) begin
            do_op(W'($urandom), W'($urandom), 1'($urandom), "rand");
            for (int g = $urandom_range(0, 3); g > 0; g--) tick();
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
